// File: rtl/led_ctl.sv
// Bussed LED output controller: synchronizes and glitch-filters bus write strobes, latching data onto leds.
// Optional combinational readback onto the data bus is compiled in with LED_CTL_READBACK_EN.
module led_ctl #(
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_ACTIVE  = 3,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_n,
    input  logic       write_n,
    input  logic       read_n,
    inout  wire  [7:0] data,
    output logic [7:0] leds,
    output logic       wr_done
);

    localparam int              CNT_W   = $clog2(MIN_ACTIVE + 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_ACTIVE);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic                        strb_raw_s;
    logic [SYNC_STAGES-2:0]      strb_sync_r;
    logic [SYNC_STAGES-2:0][7:0] data_sync_r;
    logic                        strb_s;
    logic [7:0]                  data_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [7:0]       shadow_r;
    logic [7:0]       shadow_nxt_s;
    logic [7:0]       leds_nxt_s;
    logic             wr_done_nxt_s;

    assign strb_raw_s = ~ce_n & ~write_n;

    // The FSM state and shadow registers act as the final synchronizer stage, so
    // only SYNC_STAGES-1 dedicated flops sit in front of them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_sync_r <= {(SYNC_STAGES-1){1'b0}};
            data_sync_r <= {(8*(SYNC_STAGES-1)){1'b0}};
        end else begin
            strb_sync_r[0] <= strb_raw_s;
            data_sync_r[0] <= data;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                strb_sync_r[i] <= strb_sync_r[i-1];
                data_sync_r[i] <= data_sync_r[i-1];
            end
        end
    end

    assign strb_s = strb_sync_r[SYNC_STAGES-2];
    assign data_s = data_sync_r[SYNC_STAGES-2];

    // State, qualification counter, shadow data and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            count_r  <= {CNT_W{1'b0}};
            shadow_r <= 8'h00;
            leds     <= RESET_VALUE;
            wr_done  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            shadow_r <= shadow_nxt_s;
            leds     <= leds_nxt_s;
            wr_done  <= wr_done_nxt_s;
        end
    end

    // Next-state logic: a strobe shorter than MIN_ACTIVE cycles is discarded.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        shadow_nxt_s = shadow_r;
        case (state_r)
            IDLE: begin
                if (strb_s) begin
                    state_nxt_s  = ACTIVE;
                    count_nxt_s  = ONE_CNT;
                    shadow_nxt_s = data_s;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            ACTIVE: begin
                if (strb_s) begin
                    shadow_nxt_s = data_s;
                    if (count_r < MIN_CNT) begin
                        count_nxt_s = count_r + ONE_CNT;
                    end else begin
                        count_nxt_s = count_r;
                    end
                end else if (count_r >= MIN_CNT) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COMMIT: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output logic: leds load the shadow and wr_done pulses only from COMMIT.
    always_comb begin
        leds_nxt_s    = leds;
        wr_done_nxt_s = 1'b0;
        if (state_r == COMMIT) begin
            leds_nxt_s    = shadow_r;
            wr_done_nxt_s = 1'b1;
        end else begin
            leds_nxt_s    = leds;
            wr_done_nxt_s = 1'b0;
        end
    end

`ifdef LED_CTL_READBACK_EN
    // A simultaneous write strobe keeps the bus released to avoid contention.
    assign data = (~ce_n & ~read_n & write_n) ? leds : 8'bz;
`else
    logic unused_read_s;
    assign unused_read_s = read_n;
    assign data = 8'bz;
`endif

endmodule

// File: tb/tb_led_ctl.sv
// Bench for led_ctl: vector table plus hand sequences for timing, reset and back-to-back writes,
// with a wr_done-driven scoreboard of expected leds values.
module tb_led_ctl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_n = 1'b1;
    logic       write_n = 1'b1;
    logic       read_n = 1'b1;
    logic [7:0] tb_data = 8'h00;
    logic       tb_drv = 1'b1;
    wire  [7:0] data;
    logic [7:0] leds;
    logic       wr_done;

    assign data = tb_drv ? tb_data : 8'bz;

    always #5 clk = ~clk;

    led_ctl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_n    (ce_n),
        .write_n (write_n),
        .read_n  (read_n),
        .data    (data),
        .leds    (leds),
        .wr_done (wr_done)
    );

    typedef struct {
        logic [7:0] d;
        int         hold;
        bit         accept;
        logic [7:0] exp_leds;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;
    int         done_cnt = 0;
    int         exp_done_cnt = 0;
    bit         prev_done = 1'b0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller sits at a negedge; strobe is sampled active on exactly 'hold' rising edges.
    task automatic do_write(input logic [7:0] d, input int hold, input bit accept);
        tb_data = d;
        ce_n    = 1'b0;
        write_n = 1'b0;
        if (accept) begin
            exp_q.push_back(d);
            exp_done_cnt++;
        end
        repeat (hold) @(negedge clk);
        ce_n    = 1'b1;
        write_n = 1'b1;
    endtask

    // Scoreboard monitor: every wr_done pulse pops one expected leds value.
    always @(negedge clk) begin
        if (prev_done) begin
            chk_int("wr_done_width", int'(wr_done), 0);
        end
        if (wr_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_done: leds %02h with no write pending", leds);
            end else begin
                sb_exp = exp_q.pop_front();
                chk8("scoreboard_leds", leds, sb_exp);
            end
        end
        prev_done = wr_done;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{d: 8'h3C, hold: 1, accept: 1'b0, exp_leds: 8'hA5};
        vecs[1] = '{d: 8'h77, hold: 3, accept: 1'b1, exp_leds: 8'h77};
        vecs[2] = '{d: 8'hC3, hold: 2, accept: 1'b0, exp_leds: 8'h77};
        vecs[3] = '{d: 8'h77, hold: 4, accept: 1'b1, exp_leds: 8'h77};
        vecs[4] = '{d: 8'h00, hold: 5, accept: 1'b1, exp_leds: 8'h00};
        vecs[5] = '{d: 8'hFF, hold: 8, accept: 1'b1, exp_leds: 8'hFF};

        // Reset held with an active strobe and data FF.
        ce_n    = 1'b0;
        write_n = 1'b0;
        tb_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk8("reset_leds", leds, 8'h00);
        chk_int("reset_wr_done", int'(wr_done), 0);
        exp_q.push_back(8'hFF);
        exp_done_cnt++;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        ce_n    = 1'b1;
        write_n = 1'b1;
        idle(6);
        chk8("post_reset_write", leds, 8'hFF);

        // Normal write with exact commit timing relative to edge E.
        idle(2);
        do_write(8'hA5, 6, 1'b1);
        @(negedge clk);
        chk8("timing_e0_leds", leds, 8'hFF);
        chk_int("timing_e0_done", int'(wr_done), 0);
        @(negedge clk);
        chk8("timing_e1_leds", leds, 8'hFF);
        chk_int("timing_e1_done", int'(wr_done), 0);
        @(negedge clk);
        chk8("timing_e2_leds", leds, 8'hA5);
        chk_int("timing_e2_done", int'(wr_done), 1);
        @(negedge clk);
        chk_int("timing_e3_done", int'(wr_done), 0);
        idle(3);

        for (int i = 0; i < 6; i++) begin
            idle(2);
            do_write(vecs[i].d, vecs[i].hold, vecs[i].accept);
            idle(6);
            chk8($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
            chk_int($sformatf("vec%0d_done_count", i), done_cnt, exp_done_cnt);
        end

        // Data changes while the strobe is held: last value wins.
        idle(2);
        ce_n    = 1'b0;
        write_n = 1'b0;
        tb_data = 8'h11;
        exp_q.push_back(8'h22);
        exp_done_cnt++;
        repeat (3) @(negedge clk);
        tb_data = 8'h22;
        repeat (3) @(negedge clk);
        ce_n    = 1'b1;
        write_n = 1'b1;
        idle(6);
        chk8("data_change_leds", leds, 8'h22);

        // Back-to-back writes separated by two idle cycles.
        idle(2);
        do_write(8'h01, 4, 1'b1);
        idle(2);
        do_write(8'h02, 4, 1'b1);
        idle(6);
        chk8("b2b_leds", leds, 8'h02);
        chk_int("b2b_done_count", done_cnt, exp_done_cnt);

        // Reset asserted in the middle of a write aborts it.
        idle(2);
        ce_n    = 1'b0;
        write_n = 1'b0;
        tb_data = 8'h44;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk8("reset_mid_leds", leds, 8'h00);
        chk_int("reset_mid_done", int'(wr_done), 0);
        @(negedge clk);
        ce_n    = 1'b1;
        write_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(6);
        chk8("reset_mid_after_leds", leds, 8'h00);
        chk_int("reset_mid_done_count", done_cnt, exp_done_cnt);

`ifdef LED_CTL_READBACK_EN
        idle(2);
        do_write(8'h5A, 4, 1'b1);
        idle(6);
        tb_drv = 1'b0;
        ce_n   = 1'b0;
        read_n = 1'b0;
        #1;
        chk8("readback_data", data, 8'h5A);
        tb_drv  = 1'b1;
        tb_data = 8'h96;
        write_n = 1'b0;
        #1;
        chk8("readback_write_priority", data, 8'h96);
        write_n = 1'b1;
        ce_n    = 1'b1;
        #1;
        chk8("readback_ce_high", data, 8'h96);
        read_n = 1'b1;
        idle(4);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected writes never committed", exp_q.size());
        end
        chk_int("total_done_count", done_cnt, exp_done_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
